ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the operand and result width.
REQ-002 The block SHALL take parameter CNT_W, default 6, as the iteration counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ex_aluop, input, `AluOpBus: the op from the ID/EX register; M-ops are EXOP_MUL, EXOP_MULH, EXOP_MULHSU, EXOP_MULHU, EXOP_DIV, EXOP_DIVU, EXOP_REM and EXOP_REMU per Defines.vh.
REQ-006 The block SHALL have port ex_r1_data, input, XLEN bits: operand A (rs1).
REQ-007 The block SHALL have port ex_r2_data, input, XLEN bits: operand B (rs2).
REQ-008 The block SHALL have port stall, input, 6 bits: the global stall vector; only stall[3] (EX/MEM hold) is used.
REQ-009 The block SHALL have port stallreq_md, output, 1 bit: request to ctrl to freeze IF..EX.
REQ-010 The block SHALL have port md_valid, output, 1 bit: md_result holds the final value.
REQ-011 The block SHALL have port md_result, output, XLEN bits: the M-op result, consumed by the EX result mux.
REQ-012 The block SHALL have port md_busy, output, 1 bit: high while the state is BUSY.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and DONE, held in registered state.
REQ-014 In IDLE with an M-op on ex_aluop, the block SHALL drive stallreq_md=1 combinationally in the same cycle (cycle 0).
REQ-015 At the end of cycle 0, the block SHALL capture |A|, |B|, the result-sign and op-kind, and clear the counter.
REQ-016 Signedness SHALL be: signed A and B for MULH, DIV and REM; signed A and unsigned B for MULHSU; unsigned otherwise; MUL low word is sign-independent.
REQ-017 Outside special cases, the transition from cycle 0 SHALL be IDLE->BUSY.
REQ-018 BUSY SHALL perform one shift-add (MUL*) or one restoring shift-subtract (DIV*/REM*) step per cycle, for exactly XLEN cycles (cycles 1..32), with the counter running 0..31.
REQ-019 On the counter reaching XLEN-1, the transition SHALL be BUSY->DONE.
REQ-020 stallreq_md SHALL be 1 for every BUSY cycle.
REQ-021 The multiply product SHALL use a 2*XLEN accumulator.
REQ-022 The final multiply value SHALL be the two's-complement negation of the accumulator if the result-sign is 1.
REQ-023 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-024 Quotient sign SHALL be sign(A) xor sign(B); remainder sign SHALL be sign(A); DIV/DIVU return the quotient and REM/REMU the remainder.
REQ-025 For divide by zero (B=0), the block SHALL skip BUSY and go IDLE->DONE after cycle 0.
REQ-026 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder A.
REQ-027 For signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF), the block SHALL skip BUSY and go IDLE->DONE after cycle 0.
REQ-028 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-029 In DONE, md_valid SHALL be 1 and stallreq_md SHALL be 0.
REQ-030 md_result SHALL be registered and stable for the whole DONE state.
REQ-031 DONE->IDLE SHALL occur when stall[3]=0.
REQ-032 While stall[3]=1 (downstream MEM stall), the block SHALL remain in DONE with md_result held.
REQ-033 The IDLE check SHALL NOT start on the DONE cycle, so the op that just completed is never re-issued.
REQ-034 A new M-op arriving the cycle after DONE SHALL start normally.
REQ-035 In IDLE with a non-M op, stallreq_md, md_valid and md_busy SHALL be 0, and md_result SHALL keep its last value.
REQ-036 Operand changes on ex_r*_data while BUSY SHALL be ignored; only the captured copies are used.
REQ-037 Total latency SHALL be 34 cycles for normal ops and 2 cycles for special cases, measured from op arrival to the end of the DONE cycle.

Reset
REQ-038 While rst=1 at a clock edge, the block SHALL set state=IDLE, counter=0, accumulators=0 and md_result=0x00000000, giving md_valid=0, md_busy=0 and stallreq_md=0.
REQ-039 rst SHALL take priority over every transition.
REQ-040 Reset mid-BUSY or mid-DONE SHALL abandon the operation with no result produced.
REQ-041 In the first cycle after rst deasserts with an M-op present, the block SHALL behave as an IDLE cycle 0.

Verification
REQ-042 MUL with A=7, B=0xFFFFFFFD (-3) -> stallreq_md=1 in cycles 0..32; in cycle 33, md_valid=1 and md_result=0xFFFFFFEB.
REQ-043 MULHU with A=B=0xFFFFFFFF -> md_result=0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-044 DIV with A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with A=100, B=7 -> 0x0000000E.
REQ-045 DIVU with A=5, B=0 -> md_valid=1 in cycle 1 with md_result=0xFFFFFFFF; REMU with the same operands -> 0x00000005.
REQ-046 DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000 in cycle 1; REM with the same operands -> 0x00000000.
REQ-047 rst pulsed at BUSY cycle 10 -> next cycle md_busy=0, stallreq_md=0, md_result=0; then stall[3]=1 held for 3 cycles in DONE of a later MUL 3*4 -> md_valid stays 1 with 0x0000000C held, and state is IDLE the cycle after stall[3] falls.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: holds the pipeline while it
// runs a 32-step shift-add or restoring shift-subtract on captured operand magnitudes.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6,
    parameter logic [7:0] EXOP_MUL    = 8'h30,
    parameter logic [7:0] EXOP_MULH   = 8'h31,
    parameter logic [7:0] EXOP_MULHSU = 8'h32,
    parameter logic [7:0] EXOP_MULHU  = 8'h33,
    parameter logic [7:0] EXOP_DIV    = 8'h34,
    parameter logic [7:0] EXOP_DIVU   = 8'h35,
    parameter logic [7:0] EXOP_REM    = 8'h36,
    parameter logic [7:0] EXOP_REMU   = 8'h37
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      ex_aluop,
    input  logic [XLEN-1:0] ex_r1_data,
    input  logic [XLEN-1:0] ex_r2_data,
    input  logic [5:0]      stall,
    output logic            stallreq_md,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result,
    output logic            md_busy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;
    typedef enum logic [1:0] {K_MULLO = 2'd0, K_MULHI = 2'd1, K_DIV = 2'd2, K_REM = 2'd3} kind_e;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_dw(input logic [2*XLEN-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d, kind_in;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, opa_q, opa_d, acc_step, prod_fin;
    logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d;
    logic              neg_q, neg_d;

    logic              is_mul, is_div, is_mop, op_rem, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, kind_is_mul, stall_req;
    logic [XLEN-1:0]   abs_a, abs_b, special_res, final_res;
    logic [XLEN:0]     rem_sh, diff;
    logic              unused_stall;

    assign unused_stall = ^{stall[5:4], stall[2:0]};

    always_comb begin
        is_mul   = (ex_aluop == EXOP_MUL) || (ex_aluop == EXOP_MULH) ||
                   (ex_aluop == EXOP_MULHSU) || (ex_aluop == EXOP_MULHU);
        is_div   = (ex_aluop == EXOP_DIV) || (ex_aluop == EXOP_DIVU) ||
                   (ex_aluop == EXOP_REM) || (ex_aluop == EXOP_REMU);
        is_mop   = is_mul || is_div;
        op_rem   = (ex_aluop == EXOP_REM) || (ex_aluop == EXOP_REMU);
        a_signed = (ex_aluop == EXOP_MULH) || (ex_aluop == EXOP_MULHSU) ||
                   (ex_aluop == EXOP_DIV) || (ex_aluop == EXOP_REM);
        b_signed = (ex_aluop == EXOP_MULH) || (ex_aluop == EXOP_DIV) || (ex_aluop == EXOP_REM);
        a_neg    = a_signed && ex_r1_data[XLEN-1];
        b_neg    = b_signed && ex_r2_data[XLEN-1];
        abs_a    = cond_neg(ex_r1_data, a_neg);
        abs_b    = cond_neg(ex_r2_data, b_neg);
        div_zero = is_div && (ex_r2_data == '0);
        div_ovf  = ((ex_aluop == EXOP_DIV) || (ex_aluop == EXOP_REM)) &&
                   (ex_r1_data == INT_MIN) && (ex_r2_data == '1);
        // Divide-by-zero and INT_MIN/-1 resolve without iterating.
        if (div_zero) special_res = op_rem ? ex_r1_data : '1;
        else          special_res = op_rem ? '0 : INT_MIN;
        if (ex_aluop == EXOP_MUL) kind_in = K_MULLO;
        else if (is_mul)          kind_in = K_MULHI;
        else if (op_rem)          kind_in = K_REM;
        else                      kind_in = K_DIV;
    end

    // acc holds the product for multiplies and {remainder, quotient} for divides.
    always_comb begin
        kind_is_mul = (kind_q == K_MULLO) || (kind_q == K_MULHI);
        rem_sh      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff        = rem_sh - {1'b0, opb_q};
        if (kind_is_mul)    acc_step = opb_q[0] ? acc_q + opa_q : acc_q;
        else if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        prod_fin = cond_neg_dw(acc_step, neg_q);
        case (kind_q)
            K_MULLO: final_res = prod_fin[XLEN-1:0];
            K_MULHI: final_res = prod_fin[2*XLEN-1:XLEN];
            K_DIV:   final_res = cond_neg(acc_step[XLEN-1:0], neg_q);
            default: final_res = cond_neg(acc_step[2*XLEN-1:XLEN], neg_q);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        kind_d    = kind_q;
        res_d     = res_q;
        stall_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mop) begin
                    stall_req = 1'b1;
                    kind_d    = kind_in;
                    neg_d     = op_rem ? a_neg : (a_neg ^ b_neg);
                    cnt_d     = '0;
                    acc_d     = is_mul ? '0 : {{XLEN{1'b0}}, abs_a};
                    opa_d     = {{XLEN{1'b0}}, abs_a};
                    opb_d     = abs_b;
                    if (div_zero || div_ovf) begin
                        state_d = S_DONE;
                        res_d   = special_res;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                acc_d     = acc_step;
                cnt_d     = cnt_q + CNT_W'(1);
                if (kind_is_mul) begin
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = S_DONE;
                    res_d   = final_res;
                end
            end
            S_DONE: begin
                // Leaving DONE goes to IDLE, never straight into a new start.
                if (!stall[3]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            kind_q  <= K_MULLO;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            kind_q  <= kind_d;
            res_q   <= res_d;
        end
    end

    assign stallreq_md = stall_req && !rst;
    assign md_valid    = (state_q == S_DONE);
    assign md_busy     = (state_q == S_BUSY);
    assign md_result   = res_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, randomized ops against an
// arithmetic reference model, reset and downstream-stall scenarios.
module tb_ex_muldiv;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_MUL    = 8'h30;
    localparam logic [7:0] OP_MULH   = 8'h31;
    localparam logic [7:0] OP_MULHSU = 8'h32;
    localparam logic [7:0] OP_MULHU  = 8'h33;
    localparam logic [7:0] OP_DIV    = 8'h34;
    localparam logic [7:0] OP_DIVU   = 8'h35;
    localparam logic [7:0] OP_REM    = 8'h36;
    localparam logic [7:0] OP_REMU   = 8'h37;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_r1_data, ex_r2_data;
    logic [5:0]  stall;
    logic        stallreq_md, md_valid, md_busy;
    logic [31:0] md_result;

    int errors = 0;
    int checks = 0;

    logic [7:0] ops [8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    ex_muldiv dut (
        .clk(clk), .rst(rst), .ex_aluop(ex_aluop), .ex_r1_data(ex_r1_data),
        .ex_r2_data(ex_r2_data), .stall(stall), .stallreq_md(stallreq_md),
        .md_valid(md_valid), .md_result(md_result), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_md(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, zy;
        logic [63:0] p;
        logic signed [31:0] q;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zy = {32'b0, y};
        case (op)
            OP_MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * zy; return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            OP_DIV: begin
                if (y == 32'h0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                q = $signed(x) / $signed(y);
                return q;
            end
            OP_REM: begin
                if (y == 32'h0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                q = $signed(x) % $signed(y);
                return q;
            end
            OP_DIVU: return (y == 32'h0) ? 32'hFFFFFFFF : x / y;
            OP_REMU: return (y == 32'h0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_special(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
        bit dv;
        dv = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        return (dv && y == 32'h0) ||
               ((op == OP_DIV || op == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF);
    endfunction

    // Issues one op at the start of a cycle and follows it to its DONE cycle.
    task automatic run_op(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input bit scramble, input bit drop_rst,
                          input string tag);
        int  exp_cyc, k;
        bit  busy_ok, got;
        exp_cyc = is_special(op, x, y) ? 1 : 33;
        @(posedge clk); #1;
        ex_aluop = op; ex_r1_data = x; ex_r2_data = y;
        if (drop_rst) rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stallreq_md !== 1'b1 || md_busy !== 1'b0 || md_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle0: stallreq=%b busy=%b valid=%b, required 1 0 0",
                     tag, stallreq_md, md_busy, md_valid);
        end
        busy_ok = 1; got = 0; k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (scramble) begin ex_r1_data = $urandom; ex_r2_data = $urandom; end
            @(negedge clk);
            if (md_valid === 1'b1) begin k = c; got = 1; break; end
            if (stallreq_md !== 1'b1 || md_busy !== 1'b1) busy_ok = 0;
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy_phase: stallreq/busy dropped before done, required both 1", tag);
        end
        checks++;
        if (!got || k != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: valid at cycle %0d (seen=%0d), required cycle %0d", tag, k, got, exp_cyc);
        end
        checks++;
        if (md_result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h, required %h (a=%h b=%h)", tag, md_result, exp, x, y);
        end
        checks++;
        if (stallreq_md !== 1'b0 || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: stallreq=%b busy=%b, required 0 0", tag, stallreq_md, md_busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ex_aluop = OP_MUL; ex_r1_data = 32'd7; ex_r2_data = 32'd3; stall = 6'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (md_valid !== 1'b0 || md_busy !== 1'b0 || stallreq_md !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b stallreq=%b, required 0 0 0", md_valid, md_busy, stallreq_md);
        end
        checks++;
        if (md_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h, required 00000000", md_result);
        end
        run_op(OP_MUL, 32'd7, 32'd3, 32'd21, 0, 1, "mul_after_rst");
    endtask

    task automatic test_vectors;
        logic [7:0]  vop [11] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVU,
                                  OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] va  [11] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                  32'hFFFFFFF9, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] vb  [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                  32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ve  [11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                  32'hFFFFFFFF, 32'h0000000E, 32'hFFFFFFFF, 32'h00000005,
                                  32'h80000000, 32'h00000000};
        for (int i = 0; i < 11; i++)
            run_op(vop[i], va[i], vb[i], ve[i], 0, 0, $sformatf("vec%0d", i));
    endtask

    task automatic test_back_to_back;
        run_op(OP_MULHU, 32'h12345678, 32'h9ABCDEF0, ref_md(OP_MULHU, 32'h12345678, 32'h9ABCDEF0), 0, 0, "b2b_mulhu");
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0, "b2b_divz");
        run_op(OP_REM, 32'hFFFFFF9C, 32'd7, ref_md(OP_REM, 32'hFFFFFF9C, 32'd7), 1, 0, "b2b_rem");
        run_op(OP_MUL, 32'h1234, 32'h10, 32'h12340, 1, 0, "b2b_mul");
    endtask

    task automatic test_idle_nonm(input logic [31:0] last);
        @(posedge clk); #1;
        ex_aluop = OP_NOP;
        for (int i = 0; i < 3; i++) begin
            ex_r1_data = $urandom; ex_r2_data = $urandom;
            @(negedge clk);
            checks++;
            if (stallreq_md !== 1'b0 || md_valid !== 1'b0 || md_busy !== 1'b0 || md_result !== last) begin
                errors++;
                $display("FAIL idle_nonm: stallreq=%b valid=%b busy=%b result=%h, required 0 0 0 %h",
                         stallreq_md, md_valid, md_busy, md_result, last);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        logic [7:0]  op;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = $urandom_range(1, 20);
                3: y = -$urandom_range(1, 20);
                default: ;
            endcase
            stall = {2'($urandom), 1'b0, 3'($urandom)};
            run_op(op, x, y, ref_md(op, x, y), bit'($urandom_range(0, 1)), 0, $sformatf("rand%0d", i));
        end
        stall = 6'h0;
    endtask

    task automatic test_reset_mid_busy;
        bit saw_valid;
        run_op(OP_MUL, 32'd5, 32'd5, 32'd25, 0, 0, "pre_rst_mul");
        @(posedge clk); #1;
        ex_aluop = OP_MUL; ex_r1_data = 32'd9; ex_r2_data = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin rst = 1'b1; ex_aluop = OP_NOP; end
        end
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy_pre: busy=%b at cycle 10, required 1", md_busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b0 || stallreq_md !== 1'b0 || md_valid !== 1'b0 || md_result !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_busy: busy=%b stallreq=%b valid=%b result=%h, required 0 0 0 00000000",
                     md_busy, stallreq_md, md_valid, md_result);
        end
        saw_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_valid !== 1'b0 || md_result !== 32'h0) saw_valid = 1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL rst_abandon: result produced after reset, required none");
        end
    endtask

    task automatic test_stall_hold;
        stall = 6'b001000;
        run_op(OP_MUL, 32'd3, 32'd4, 32'h0000000C, 0, 0, "stall_mul");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (md_valid !== 1'b1 || md_result !== 32'h0000000C || stallreq_md !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b result=%h stallreq=%b, required 1 0000000c 0",
                         i, md_valid, md_result, stallreq_md);
            end
        end
        @(posedge clk); #1;
        stall = 6'b000000;
        @(negedge clk);
        checks++;
        if (md_valid !== 1'b1 || md_result !== 32'h0000000C) begin
            errors++;
            $display("FAIL stall_release_done: valid=%b result=%h, required 1 0000000c", md_valid, md_result);
        end
        @(posedge clk); #1;
        ex_aluop = OP_NOP;
        @(negedge clk);
        checks++;
        if (md_valid !== 1'b0 || md_busy !== 1'b0 || stallreq_md !== 1'b0 || md_result !== 32'h0000000C) begin
            errors++;
            $display("FAIL stall_to_idle: valid=%b busy=%b stallreq=%b result=%h, required 0 0 0 0000000c",
                     md_valid, md_busy, stallreq_md, md_result);
        end
    endtask

    initial begin
        rst = 1'b1; ex_aluop = OP_NOP; ex_r1_data = '0; ex_r2_data = '0; stall = 6'h0;
        test_reset;
        test_vectors;
        test_back_to_back;
        test_idle_nonm(32'h00012340);
        test_random;
        test_reset_mid_busy;
        test_stall_hold;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
